// File: rtl/out_buffer_pkg.sv
// Shared types and default geometry for the out_buffer output stream packer.
package out_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_IN_WIDTH    = 64;
  localparam int unsigned DEF_OUT_WIDTH   = 256;
  localparam int unsigned DEF_FIFO_DEPTH  = 512;
  localparam int unsigned DEF_COUNT_WIDTH = 10;
  localparam int unsigned DEF_LEN_WIDTH   = 24;

  localparam int unsigned LANES     = DEF_OUT_WIDTH / DEF_IN_WIDTH;
  localparam int unsigned LANE_BITS = $clog2(LANES);

  // FIFO entry: the last-word tag sits above the packed data word.
  typedef struct packed {
    logic                     last;
    logic [DEF_OUT_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/out_buffer_if.sv
// Job control, narrow result stream and packed DMA stream of out_buffer.
interface out_buffer_if
  import out_buffer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH
);
  logic                 Start;
  logic [LEN_WIDTH-1:0] Total_Len;
  logic                 Busy;
  logic                 Done;
  logic [IN_WIDTH-1:0]  S_Data;
  logic                 S_Valid;
  logic                 S_Ready;
  logic [OUT_WIDTH-1:0] M_Data;
  logic                 M_Valid;
  logic                 M_Ready;
  logic                 M_Last;

  modport master (
    output Start, Total_Len, S_Data, S_Valid, M_Ready,
    input  Busy, Done, S_Ready, M_Data, M_Valid, M_Last
  );

  modport slave (
    input  Start, Total_Len, S_Data, S_Valid, M_Ready,
    output Busy, Done, S_Ready, M_Data, M_Valid, M_Last
  );
endinterface

// File: rtl/out_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module out_buffer_fifo #(
  parameter int unsigned WIDTH       = 257,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [COUNT_WIDTH-1:0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   do_wr, do_rd;

  always_comb begin
    full_o   = (count_q == COUNT_WIDTH'(DEPTH));
    empty_o  = (count_q == '0);
    do_wr    = wr_en_i && !full_o;
    do_rd    = rd_en_i && !empty_o;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - COUNT_WIDTH'(1);
    end
    // Head is zero while empty so the output is defined straight out of reset.
    rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    count_o   = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end
endmodule

// File: rtl/out_buffer.sv
// Packs narrow result beats into wide words, queues them and drains to DMA.
// Build option: define OUT_BUFFER_PAD_EN to accept lengths not a multiple of the lane count.
module out_buffer
  import out_buffer_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int unsigned LEN_WIDTH   = DEF_LEN_WIDTH
) (
  input logic         clk,
  input logic         rst,
  out_buffer_if.slave bus
);
  localparam int unsigned NUM_LANES = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned LB        = $clog2(NUM_LANES);
  localparam logic [LB-1:0] LAST_LANE = LB'(NUM_LANES - 1);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] eff_len_q, words_q, in_cnt_q, out_cnt_q;
  logic [LEN_WIDTH-1:0] start_eff, start_words;
  logic [LB-1:0]        lane_q;
  logic [OUT_WIDTH-1:0] pack_q, word_next;
  logic [OUT_WIDTH:0]   fifo_wdata, fifo_rdata;
  logic [COUNT_WIDTH-1:0] fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 start_ok, final_beat, word_done, s_ready, s_fire, push, pop;

  always_comb begin
`ifdef OUT_BUFFER_PAD_EN
    start_eff   = bus.Total_Len;
    start_words = (bus.Total_Len >> LB) + LEN_WIDTH'(|bus.Total_Len[LB-1:0]);
`else
    start_eff   = bus.Total_Len & ~LEN_WIDTH'(NUM_LANES - 1);
    start_words = bus.Total_Len >> LB;
`endif
  end

  always_comb begin
    start_ok   = (state_q == IDLE) && bus.Start;
    final_beat = (in_cnt_q + LEN_WIDTH'(1) == eff_len_q);
`ifdef OUT_BUFFER_PAD_EN
    // A short final word closes early; upper lanes are already zero in pack_q.
    word_done  = (lane_q == LAST_LANE) || final_beat;
`else
    word_done  = (lane_q == LAST_LANE);
`endif
    s_ready    = (state_q == RUN) && (in_cnt_q < eff_len_q) && (!word_done || !fifo_full);
    s_fire     = bus.S_Valid && s_ready;
    push       = s_fire && word_done;
    pop        = !fifo_empty && bus.M_Ready;
    word_next  = pack_q;
    word_next[lane_q*IN_WIDTH +: IN_WIDTH] = bus.S_Data;
    fifo_wdata = {final_beat, word_next};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Zero-length jobs pass through DRAIN so Done lands two cycles after Start;
  // DRAIN looks at this cycle's pop so Done follows the final handshake directly.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_ok) state_d = (start_eff == '0) ? DRAIN : RUN;
      RUN:   if (s_fire && final_beat) state_d = DRAIN;
      DRAIN: if ((out_cnt_q == words_q) ||
                 (pop && (out_cnt_q + LEN_WIDTH'(1) == words_q))) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy    = (state_q != IDLE);
    bus.Done    = (state_q == DONE);
    bus.S_Ready = s_ready;
    bus.M_Valid = !fifo_empty;
    bus.M_Data  = fifo_rdata[OUT_WIDTH-1:0];
    bus.M_Last  = !fifo_empty && fifo_rdata[OUT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eff_len_q <= '0;
      words_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
    end else if (start_ok) begin
      eff_len_q <= start_eff;
      words_q   <= start_words;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
    end else begin
      if (s_fire) begin
        in_cnt_q <= in_cnt_q + LEN_WIDTH'(1);
        if (word_done) begin
          lane_q <= '0;
          pack_q <= '0;
        end else begin
          lane_q <= lane_q + LB'(1);
          pack_q <= word_next;
        end
      end
      if (pop) begin
        out_cnt_q <= out_cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  out_buffer_fifo #(
    .WIDTH       (OUT_WIDTH + 1),
    .DEPTH       (FIFO_DEPTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= COUNT_WIDTH'(FIFO_DEPTH));
endmodule
